// File: rtl/tport_pkg.sv
// Shared definitions for the two-master instruction port arbiter.
package tport_pkg;

  localparam logic TP_M0     = 1'b0;
  localparam logic TP_M1     = 1'b1;
  localparam int   TP_DATA_W = 32;
  localparam int   TP_PRIV_W = 2;

  // Pick the master that owns the shared request port this cycle.
  // With nobody requesting the answer still favours the master that would
  // win the next tie, so ready is offered to it without waiting a cycle.
  function automatic logic pick_grant(input logic v0, input logic v1,
                                      input logic rr_last, input logic fixed_prio);
    logic g;
    if (v0 && v1)
      g = fixed_prio ? TP_M0 : ~rr_last;
    else if (v1)
      g = TP_M1;
    else if (v0)
      g = TP_M0;
    else
      g = fixed_prio ? TP_M0 : ~rr_last;
    return g;
  endfunction

endpackage

// File: rtl/tport_tag_fifo.sv
// Small FIFO of 1-bit master tags remembering the order requests were granted.
module tport_tag_fifo
  import tport_pkg::*;
#(
  parameter int DEPTHX = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int DEPTH = 1 << DEPTHX;

  logic [DEPTH-1:0]  mem;
  logic [DEPTHX-1:0] wr_ptr;
  logic [DEPTHX-1:0] rd_ptr;
  logic [DEPTHX:0]   count;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is refused even if a pop lands in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (DEPTHX+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Tag storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at the depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tport_arbiter.sv
// Shares one in-order instruction memory port between core fetch (M0) and
// debug/loader (M1); responses are steered back using the tag FIFO order.
module tport_arbiter
  import tport_pkg::*;
#(
  parameter int C_OTDEPTHX   = 2,
  parameter bit C_FIXED_PRIO = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 m0_treqready,
  input  logic                 m0_treqvalid,
  input  logic [TP_PRIV_W-1:0] m0_treqpriv,
  input  logic [TP_DATA_W-1:0] m0_treqaddr,
  input  logic                 m0_trspready,
  output logic                 m0_trspvalid,
  output logic                 m0_trsprerr,
  output logic [TP_DATA_W-1:0] m0_trspdata,
  output logic                 m1_treqready,
  input  logic                 m1_treqvalid,
  input  logic [TP_PRIV_W-1:0] m1_treqpriv,
  input  logic [TP_DATA_W-1:0] m1_treqaddr,
  input  logic                 m1_trspready,
  output logic                 m1_trspvalid,
  output logic                 m1_trsprerr,
  output logic [TP_DATA_W-1:0] m1_trspdata,
  input  logic                 s_treqready,
  output logic                 s_treqvalid,
  output logic [TP_PRIV_W-1:0] s_treqpriv,
  output logic [TP_DATA_W-1:0] s_treqaddr,
  output logic                 s_trspready,
  input  logic                 s_trspvalid,
  input  logic                 s_trsprerr,
  input  logic [TP_DATA_W-1:0] s_trspdata,
  output logic                 orphan_err
);

  logic grant;
  logic rr_last;
  logic fifo_full;
  logic fifo_empty;
  logic head;
  logic push;
  logic pop;

  tport_tag_fifo #(
    .DEPTHX (C_OTDEPTHX)
  ) u_tags (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (grant),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Request side: pick a winner and forward it with no added latency.
  always_comb begin
    grant        = pick_grant(m0_treqvalid, m1_treqvalid, rr_last, C_FIXED_PRIO);
    s_treqvalid  = (m0_treqvalid | m1_treqvalid) & ~fifo_full;
    s_treqpriv   = (grant == TP_M1) ? m1_treqpriv : m0_treqpriv;
    s_treqaddr   = (grant == TP_M1) ? m1_treqaddr : m0_treqaddr;
    m0_treqready = s_treqready & ~fifo_full & (grant == TP_M0);
    m1_treqready = s_treqready & ~fifo_full & (grant == TP_M1);
    push         = s_treqvalid & s_treqready;
  end

  // Response side: the oldest outstanding tag decides who sees the response.
  always_comb begin
    s_trspready  = ~fifo_empty & ((head == TP_M1) ? m1_trspready : m0_trspready);
    m0_trspvalid = s_trspvalid & ~fifo_empty & (head == TP_M0);
    m1_trspvalid = s_trspvalid & ~fifo_empty & (head == TP_M1);
    m0_trsprerr  = s_trsprerr;
    m1_trsprerr  = s_trsprerr;
    m0_trspdata  = s_trspdata;
    m1_trspdata  = s_trspdata;
    pop          = s_trspvalid & s_trspready;
  end

  // Remember the last accepted winner so ties alternate; M0 takes the first tie.
  always_ff @(posedge clk) begin
    if (reset)
      rr_last <= TP_M1;
    else if (push)
      rr_last <= grant;
  end

  // A response with nothing outstanding is dropped and flagged until reset.
  always_ff @(posedge clk) begin
    if (reset)
      orphan_err <= 1'b0;
    else if (s_trspvalid && fifo_empty)
      orphan_err <= 1'b1;
  end

endmodule
